// File: rtl/morra_pkg.sv
// Shared codes and FSM states for the Morra Cinese scoreboard.
package morra_pkg;

  localparam logic [1:0] ESITO_NULLO    = 2'b00;
  localparam logic [1:0] ESITO_PRIMO    = 2'b01;
  localparam logic [1:0] ESITO_SECONDO  = 2'b10;
  localparam logic [1:0] ESITO_PAREGGIO = 2'b11;

  typedef enum logic [1:0] {
    ATTESA,
    GIOCO,
    FINE
  } stato_t;

endpackage

// File: rtl/contatore_sat.sv
// Saturating up-counter with synchronous clear and async reset.
module contatore_sat #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (inc && (q != {W{1'b1}}))
      q <= q + W'(1);
  end

endmodule

// File: rtl/morra_tabellone.sv
// Game scoreboard: round count, cumulative tallies and a
// one-entry result buffer offered to a logger via valid/ack.
module morra_tabellone
  import morra_pkg::*;
#(
  parameter int CW = 8,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          INIZIO,
  input  logic [1:0]    MANCHE,
  input  logic [1:0]    PARTITA,
  input  logic          RIS_ACK,
  output logic [CW-1:0] VITTORIE_PRIMO,
  output logic [CW-1:0] VITTORIE_SECONDO,
  output logic [CW-1:0] PAREGGI,
  output logic [RW-1:0] MANCHE_GIOCATE,
  output logic          RIS_VALID,
  output logic [1:0]    RIS_ESITO,
  output logic [RW-1:0] RIS_MANCHE,
  output logic          PERSO
);

  stato_t        stato;
  stato_t        stato_nx;
  logic          gioca;
  logic          tick;
  logic          fine;
  logic [RW-1:0] manche_fin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stato <= ATTESA;
    else
      stato <= stato_nx;
  end

  always_comb begin
    stato_nx = stato;
    gioca    = (stato == GIOCO) && !INIZIO;
    tick     = gioca && (MANCHE != ESITO_NULLO);
    fine     = gioca && (PARTITA != ESITO_NULLO);
    if (INIZIO)
      stato_nx = GIOCO;
    else if (fine)
      stato_nx = FINE;
  end

  // A round sampled together with the game end belongs to that game.
  always_comb begin
    manche_fin = MANCHE_GIOCATE;
    if (tick && (MANCHE_GIOCATE != {RW{1'b1}}))
      manche_fin = MANCHE_GIOCATE + RW'(1);
  end

  contatore_sat #(.W(RW)) u_manche (
    .clk (clk),
    .rst (rst),
    .clr (INIZIO),
    .inc (tick),
    .q   (MANCHE_GIOCATE)
  );

  contatore_sat #(.W(CW)) u_primo (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (fine && (PARTITA == ESITO_PRIMO)),
    .q   (VITTORIE_PRIMO)
  );

  contatore_sat #(.W(CW)) u_secondo (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (fine && (PARTITA == ESITO_SECONDO)),
    .q   (VITTORIE_SECONDO)
  );

  contatore_sat #(.W(CW)) u_pareggi (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (fine && (PARTITA == ESITO_PAREGGIO)),
    .q   (PAREGGI)
  );

  // Free slot or same-edge ack reloads; otherwise the result is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RIS_VALID  <= 1'b0;
      RIS_ESITO  <= ESITO_NULLO;
      RIS_MANCHE <= '0;
      PERSO      <= 1'b0;
    end else if (fine) begin
      if (!RIS_VALID || RIS_ACK) begin
        RIS_VALID  <= 1'b1;
        RIS_ESITO  <= PARTITA;
        RIS_MANCHE <= manche_fin;
      end else begin
        PERSO <= 1'b1;
      end
    end else if (RIS_VALID && RIS_ACK) begin
      RIS_VALID <= 1'b0;
    end
  end

endmodule

// File: doc/morra_tabellone.md
Name: morra_tabellone

Overview:
Downstream scoreboard for the MorraCinese FSMD. It samples MANCHE/PARTITA every clk edge and counts played rounds in the current game. It keeps cumulative game tallies across games and presents each concluded game result to a logger through a valid/ack handshake. Pure consumer: no feedback into MorraCinese.

Parameters:
CW, 8, width of cumulative game counters (saturating)
RW, 5, width of per-game round counter (saturating)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
INIZIO  in  1  same signal driven to MorraCinese; starts a new game
MANCHE  in  2  round result from MorraCinese: 00 none, 01 PRIMO wins, 10 SECONDO wins, 11 draw
PARTITA  in  2  game result from MorraCinese: 00 ongoing, 01 PRIMO, 10 SECONDO, 11 draw
RIS_ACK  in  1  logger accepts RIS_ESITO/RIS_MANCHE
VITTORIE_PRIMO  out  CW  games won by PRIMO
VITTORIE_SECONDO  out  CW  games won by SECONDO
PAREGGI  out  CW  drawn games
MANCHE_GIOCATE  out  RW  valid rounds (MANCHE!=00) in current/last game
RIS_VALID  out  1  concluded-game result pending
RIS_ESITO  out  2  PARTITA code of pending result
RIS_MANCHE  out  RW  round count of pending game
PERSO  out  1  sticky: a result was dropped (overrun)

Behaviour:
- Reset (async, rst=1): all counters 0, RIS_VALID=0, RIS_ESITO=00, RIS_MANCHE=0, PERSO=0, state ATTESA. All outputs registered.
- FSM states: ATTESA (no game), GIOCO (game running), FINE (game concluded).
- ATTESA: ignores MANCHE/PARTITA. INIZIO=1 -> GIOCO, MANCHE_GIOCATE<=0.
- GIOCO, per edge, INIZIO=0:
  - MANCHE!=00 -> MANCHE_GIOCATE+1, saturating at 2^RW-1.
  - PARTITA!=00 -> FINE. Tally counter for PRIMO/SECONDO/draw +1, saturating at 2^CW-1. Result is offered to logger (below).
  - PARTITA and MANCHE both nonzero in same cycle: count the round first; RIS_MANCHE includes it.
- GIOCO with INIZIO=1: abandon game, no tally, MANCHE_GIOCATE<=0, stay GIOCO.
- FINE: ignores MANCHE/PARTITA; MANCHE_GIOCATE holds. INIZIO=1 -> GIOCO, MANCHE_GIOCATE<=0.
- INIZIO has priority over MANCHE/PARTITA in every state. The sample cycle where INIZIO=1 is never counted.
- Output handshake (1-entry buffer):
  - Offer in cycle N, RIS_VALID=0: next edge RIS_VALID=1, RIS_ESITO=PARTITA, RIS_MANCHE=final count.
  - RIS_VALID=1 and RIS_ACK=1 at an edge: RIS_VALID<=0.
  - Offer while RIS_VALID=1 and RIS_ACK=1 same edge: buffer reloads with new result, RIS_VALID stays 1.
  - Offer while RIS_VALID=1 and RIS_ACK=0: new result dropped, PERSO<=1. Tallies still update.
  - PERSO clears only on rst.
  - RIS_ESITO/RIS_MANCHE stable while RIS_VALID=1 and not acked.
- Latency: tally and RIS_VALID update 1 edge after PARTITA!=00 is sampled.
- rst mid-game or with result pending: everything cleared immediately; pending result lost without PERSO.

Decomposition:
- Package morra_pkg holds:
  - 2-bit codes ESITO_NULLO=00, ESITO_PRIMO=01, ESITO_SECONDO=10, ESITO_PAREGGIO=11, shared by MANCHE/PARTITA.
  - FSM state enum (ATTESA, GIOCO, FINE).
- One sub-module: contatore_sat (parameterised width, inc, clr, async rst). Instantiated 4 times.

Test Plan:
- rst pulse, then MANCHE=01/PARTITA=01 with no INIZIO -> all counters stay 0, RIS_VALID=0 (ATTESA ignores inputs).
- INIZIO=1, then MANCHE 01,10,11,01 with PARTITA=00, then MANCHE=01/PARTITA=01 -> MANCHE_GIOCATE=5, VITTORIE_PRIMO=1, RIS_VALID=1, RIS_ESITO=01, RIS_MANCHE=5.
- RIS_ACK held 0, second game ends with PARTITA=10 -> VITTORIE_SECONDO=1, PERSO=1, RIS_ESITO still 01; ACK then -> RIS_VALID=0.
- Game in progress (3 rounds), INIZIO=1 -> MANCHE_GIOCATE=0, no tally change; then PARTITA=11 -> PAREGGI=1, RIS_MANCHE counts only post-restart rounds.
- CW=2: four PRIMO wins -> VITTORIE_PRIMO saturates at 3. RW=2: five rounds -> MANCHE_GIOCATE=3.
- RIS_VALID=1 with RIS_ACK=1 on same edge as a new game end -> RIS_VALID stays 1 with new ESITO, PERSO=0; rst asserted mid-game -> all outputs 0 immediately, asynchronously.
